// File: rtl/manch_pkg.sv
// manch_pkg: shared FSM states, polarity constants and mid-bit window bounds for the Manchester receiver
package manch_pkg;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam int POLARITY_IEEE   = 0;
    localparam int POLARITY_THOMAS = 1;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
    } win_t;

    // Mid-bit edges are expected one bit period apart; accept +/- a quarter bit of jitter.
    function automatic win_t win_bounds(input int osr);
        win_t w;
        w.lo = 16'(3 * osr / 4);
        w.hi = 16'(5 * osr / 4);
        return w;
    endfunction

endpackage

// File: rtl/manch_sync.sv
// manch_sync: 2-flop synchroniser, registered rise/fall detector and saturating low-run counter
module manch_sync #(
    parameter int OSR = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic datamin,
    output logic rise,
    output logic fall,
    output logic armed
);
    localparam int LW = $clog2(OSR / 4 + 1);

    logic s1, s2, s3;
    logic [LW-1:0] low_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            low_cnt <= '0;
        end else begin
            s1      <= datamin;
            s2      <= s1;
            s3      <= s2;
            rise    <= s2 & ~s3;
            fall    <= ~s2 & s3;
            low_cnt <= s3 ? '0 : (low_cnt == LW'(OSR / 4)) ? low_cnt : low_cnt + 1'b1;
        end
    end

    // s3 lags the pulse source by one cycle, so the count still covers the low run when rise fires.
    assign armed = low_cnt == LW'(OSR / 4);

endmodule

// File: rtl/manch_rx_word.sv
// manch_rx_word: Manchester frame receiver (start bit + WORD_W data bits, MSB first).
// Define MANCH_RX_PARITY_EN to receive and check a trailing even-parity bit.
module manch_rx_word
    import manch_pkg::*;
#(
    parameter int OSR      = 8,
    parameter int WORD_W   = 8,
    parameter int POLARITY = POLARITY_IEEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              datamin,
    output logic [WORD_W-1:0] databout,
    output logic              dvalid,
    output logic              err,
    output logic              busy
);
`ifdef MANCH_RX_PARITY_EN
    localparam int NB = WORD_W + 1;
`else
    localparam int NB = WORD_W;
`endif
    localparam int   IW  = $clog2(2 * OSR) + 1;
    localparam int   BW  = $clog2(NB + 1);
    localparam win_t WIN = win_bounds(OSR);
    localparam logic [IW-1:0] LO  = IW'(WIN.lo);
    localparam logic [IW-1:0] HI  = IW'(WIN.hi);
    localparam logic [IW-1:0] TMO = IW'(WIN.hi + 16'd1);

    logic rise, fall, armed;
    logic mid, last, bad;
    logic [NB-1:0] shreg, nxt;
    logic [WORD_W-1:0] word;
    logic [IW-1:0] ival;
    logic [BW-1:0] nbit;
    state_t state;

    manch_sync #(.OSR(OSR)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .datamin(datamin),
        .rise   (rise),
        .fall   (fall),
        .armed  (armed)
    );

    always_comb begin
        mid  = (rise | fall) && ival >= LO && ival <= HI;
        nxt  = (shreg << 1) | NB'(rise ^ 1'(POLARITY));
        last = nbit == BW'(NB - 1);
`ifdef MANCH_RX_PARITY_EN
        word = nxt[NB-1:1];
        bad  = ^nxt;
`else
        word = nxt;
        bad  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ival     <= '0;
            nbit     <= '0;
            shreg    <= '0;
            databout <= '0;
            dvalid   <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            dvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: if (rise && armed) begin
                    state <= RECV;
                    ival  <= '0;
                    nbit  <= '0;
                    shreg <= '0;
                    busy  <= 1'b1;
                end
                RECV: if (ival >= TMO) begin
                    state <= IDLE;
                    shreg <= '0;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                end else if (mid) begin
                    ival  <= '0;
                    shreg <= nxt;
                    nbit  <= nbit + 1'b1;
                    if (last) begin
                        // A parity failure takes the place of dvalid and leaves databout untouched.
                        state  <= DONE;
                        dvalid <= ~bad;
                        err    <= bad;
                        if (!bad) databout <= word;
                    end
                end else begin
                    ival <= (ival == '1) ? ival : ival + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manch_rx_word.sv
// tb_manch_rx_word: directed bench driving one line into IEEE and Thomas receivers side by side
module tb_manch_rx_word;
    import manch_pkg::*;

    localparam int OSR = 8;
    localparam int W   = 8;

    logic clk = 1'b0, rst = 1'b1, datamin = 1'b0;
    logic [W-1:0] dout_i, dout_t;
    logic dv_i, dv_t, err_i, err_t, busy_i, busy_t;
    int passed = 0, total = 0;
    int ndv_i = 0, nerr_i = 0, ndv_t = 0, nerr_t = 0, nboth = 0;
    int d0, e0, et0;
    logic [31:0] b;
    int n;

    always #5 clk = ~clk;

    manch_rx_word #(.OSR(OSR), .WORD_W(W), .POLARITY(POLARITY_IEEE)) u_ieee (
        .clk(clk), .rst(rst), .datamin(datamin),
        .databout(dout_i), .dvalid(dv_i), .err(err_i), .busy(busy_i)
    );

    manch_rx_word #(.OSR(OSR), .WORD_W(W), .POLARITY(POLARITY_THOMAS)) u_thomas (
        .clk(clk), .rst(rst), .datamin(datamin),
        .databout(dout_t), .dvalid(dv_t), .err(err_t), .busy(busy_t)
    );

    always @(posedge clk) begin
        if (dv_i) ndv_i++;
        if (err_i) nerr_i++;
        if (dv_t) ndv_t++;
        if (err_t) nerr_t++;
        if ((dv_i && err_i) || (dv_t && err_t)) nboth++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build(input logic [W-1:0] d, input logic p, output logic [31:0] bits, output int nb);
        bits = {23'd0, 1'b1, d};
        nb   = W + 1;
`ifdef MANCH_RX_PARITY_EN
        bits = {bits[30:0], p};
        nb++;
`endif
    endtask

    // Sends nb bits MSB first and returns right after driving the last mid-bit transition.
    task automatic frame_to_mid(input logic [31:0] bits, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            datamin = ~bits[i];
            repeat (OSR / 2) @(negedge clk);
            datamin = bits[i];
            if (i > 0) repeat (OSR / 2) @(negedge clk);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic p, input int gap);
        logic [31:0] fb;
        int fn;
        build(d, p, fb, fn);
        frame_to_mid(fb, fn);
        repeat (OSR / 2) @(negedge clk);
        datamin = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout", dout_i, 0);
        check("rst_dvalid", dv_i, 0);
        check("rst_err", err_i, 0);
        check("rst_busy", busy_i, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        d0 = ndv_i; e0 = nerr_i; et0 = nerr_t;
        build(8'hA5, ^8'hA5, b, n);
        frame_to_mid(b, n);
        repeat (3) @(negedge clk);
        check("a5_dv_early", dv_i, 0);
        @(negedge clk);
        check("a5_dv_lat4", dv_i, 1);
        check("a5_dout", dout_i, 8'hA5);
        check("a5_busy_done", busy_i, 1);
        datamin = 1'b0;
        @(negedge clk);
        check("a5_dv_pulse", dv_i, 0);
        check("a5_busy_idle", busy_i, 0);
        repeat (OSR) @(negedge clk);
        check("a5_ndv", ndv_i - d0, 1);
        check("a5_nerr", nerr_i - e0, 0);
`ifdef MANCH_RX_PARITY_EN
        check("a5_thomas_perr", nerr_t - et0, 1);
        check("a5_thomas_dout", dout_t, 8'h00);
`else
        check("a5_thomas_dout", dout_t, 8'h5A);
        check("a5_thomas_nerr", nerr_t - et0, 0);
`endif

        d0 = ndv_i; e0 = nerr_i;
        frame_to_mid(32'b11010, 5);
        repeat (15) @(negedge clk);
        check("tmo_err_early", err_i, 0);
        check("tmo_busy_early", busy_i, 1);
        @(negedge clk);
        check("tmo_err", err_i, 1);
        check("tmo_busy", busy_i, 0);
        @(negedge clk);
        check("tmo_err_pulse", err_i, 0);
        repeat (OSR) @(negedge clk);
        check("tmo_ndv", ndv_i - d0, 0);
        check("tmo_nerr", nerr_i - e0, 1);
        check("tmo_dout_hold", dout_i, 8'hA5);

        e0 = nerr_i;
        frame_to_mid(32'b1101, 4);
        repeat (OSR / 2) @(negedge clk);
        check("mid_busy", busy_i, 1);
        #2 rst = 1'b1; datamin = 1'b0;
        #1;
        check("mid_rst_dout", dout_i, 0);
        check("mid_rst_busy", busy_i, 0);
        check("mid_rst_dv", dv_i, 0);
        check("mid_rst_err", err_i, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(8'h3C, ^8'h3C, OSR);
        check("3c_dout", dout_i, 8'h3C);
        check("rst_no_err", nerr_i - e0, 0);
`ifndef MANCH_RX_PARITY_EN
        check("3c_thomas_dout", dout_t, 8'hC3);
`endif

        d0 = ndv_i; e0 = nerr_i;
        send(8'hFF, ^8'hFF, OSR / 4);
        check("ff1_dout", dout_i, 8'hFF);
        check("ff1_ndv", ndv_i - d0, 1);
        send(8'hFF, ^8'hFF, OSR);
        check("ff2_ndv", ndv_i - d0, 2);
        check("ff2_dout", dout_i, 8'hFF);
        check("ff_nerr", nerr_i - e0, 0);

`ifdef MANCH_RX_PARITY_EN
        d0 = ndv_i; e0 = nerr_i;
        send(8'h01, 1'b0, OSR);
        check("par_bad_nerr", nerr_i - e0, 1);
        check("par_bad_ndv", ndv_i - d0, 0);
        check("par_bad_dout", dout_i, 8'hFF);
        send(8'h01, 1'b1, OSR);
        check("par_ok_ndv", ndv_i - d0, 1);
        check("par_ok_dout", dout_i, 8'h01);
        check("par_ok_nerr", nerr_i - e0, 1);
`endif

        check("err_dv_overlap", nboth, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
